mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 92 +++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fetch (IF) and memory-access (MA) share one
// synchronous memory port; MA has priority with a starvation escape for IF.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_stall,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [15:0] ma_addr,
  input  logic [15:0] ma_wdata,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [15:0] ma_rdata,
  output logic [15:0] to_mem_addr,
  output logic [15:0] core_to_mem_data,
  output logic        core_to_mem_write_enable,
  input  logic [15:0] from_mem_data
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_IF_RD = 2'd1,
    TAG_MA_RD = 2'd2,
    TAG_MA_WR = 2'd3
  } tag_t;

  logic [1:0] starve_cnt;
  tag_t       tag_s1;
  tag_t       tag_s2;
  tag_t       grant_tag;
  logic       if_win;

  // IF wins alone, or when MA has beaten it three times in a row.
  assign if_win   = if_req && (!ma_req || starve_cnt == 2'd3);
  assign if_gnt   = !rst && if_win;
  assign ma_gnt   = !rst && ma_req && !if_win;
  assign if_stall = !rst && if_req && !if_win;

  always_comb begin
    grant_tag = TAG_NONE;
    if (if_gnt)
      grant_tag = TAG_IF_RD;
    else if (ma_gnt)
      grant_tag = ma_we ? TAG_MA_WR : TAG_MA_RD;
  end

  // Stage 2 holds the owner of the data returned in the previous cycle,
  // so the valid pulses are a direct decode of that register.
  assign if_rvalid = (tag_s2 == TAG_IF_RD);
  assign ma_rvalid = (tag_s2 == TAG_MA_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt               <= 2'd0;
      tag_s1                   <= TAG_NONE;
      tag_s2                   <= TAG_NONE;
      to_mem_addr              <= 16'h0000;
      core_to_mem_data         <= 16'h0000;
      core_to_mem_write_enable <= 1'b0;
      if_rdata                 <= 16'h0000;
      ma_rdata                 <= 16'h0000;
    end else begin
      if (!if_req || if_gnt)
        starve_cnt <= 2'd0;
      else if (ma_gnt && starve_cnt != 2'd3)
        starve_cnt <= starve_cnt + 2'd1;

      tag_s1 <= grant_tag;
      tag_s2 <= tag_s1;

      if (if_gnt)
        to_mem_addr <= if_addr;
      else if (ma_gnt)
        to_mem_addr <= ma_addr;

      if (grant_tag == TAG_MA_WR)
        core_to_mem_data <= ma_wdata;
      core_to_mem_write_enable <= (grant_tag == TAG_MA_WR);

      if (tag_s1 == TAG_IF_RD)
        if_rdata <= from_mem_data;
      if (tag_s1 == TAG_MA_RD)
        ma_rdata <= from_mem_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle history model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ma_req, ma_we;
  logic [15:0] if_addr, ma_addr, ma_wdata, from_mem_data;
  logic        if_gnt, if_stall, if_rvalid, ma_gnt, ma_rvalid, core_to_mem_write_enable;
  logic [15:0] if_rdata, ma_rdata, to_mem_addr, core_to_mem_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .to_mem_addr(to_mem_addr), .core_to_mem_data(core_to_mem_data),
    .core_to_mem_write_enable(core_to_mem_write_enable),
    .from_mem_data(from_mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: per-cycle history of grants ----------------
  localparam int K_NONE = 0, K_IF = 1, K_MR = 2, K_MW = 3;
  localparam int HMAX = 1024;
  int          kind_h [HMAX];
  logic        rst_h  [HMAX];
  logic [15:0] addr_h [HMAX];
  logic [15:0] wd_h   [HMAX];
  logic [15:0] data_h [HMAX];
  int          cyc = 0;
  int          m_starve = 0;
  logic [15:0] m_addr, m_wdata, m_ifd, m_mad;

  always @(negedge clk) begin
    int  k;
    logic ar, e_we, e_ifv, e_mav;
    if (cyc < HMAX) begin
      rst_h[cyc]  = rst;
      data_h[cyc] = from_mem_data;
      if (rst)                                  k = K_NONE;
      else if (if_req && (!ma_req || m_starve == 3)) k = K_IF;
      else if (ma_req)                          k = ma_we ? K_MW : K_MR;
      else                                      k = K_NONE;
      kind_h[cyc] = k;
      addr_h[cyc] = (k == K_IF) ? if_addr : ma_addr;
      wd_h[cyc]   = ma_wdata;

      chk("m_if_gnt",   {15'd0, if_gnt},   {15'd0, k == K_IF});
      chk("m_ma_gnt",   {15'd0, ma_gnt},   {15'd0, k == K_MR || k == K_MW});
      chk("m_if_stall", {15'd0, if_stall}, {15'd0, !rst && if_req && k != K_IF});

      if (cyc >= 1) begin
        ar = rst_h[cyc-1];
        if (ar) begin
          m_addr = 0; m_wdata = 0; m_ifd = 0; m_mad = 0;
        end else begin
          if (kind_h[cyc-1] != K_NONE) m_addr  = addr_h[cyc-1];
          if (kind_h[cyc-1] == K_MW)   m_wdata = wd_h[cyc-1];
        end
        e_we  = !ar && kind_h[cyc-1] == K_MW;
        e_ifv = !ar && cyc >= 2 && kind_h[cyc-2] == K_IF;
        e_mav = !ar && cyc >= 2 && kind_h[cyc-2] == K_MR;
        if (e_ifv) m_ifd = data_h[cyc-1];
        if (e_mav) m_mad = data_h[cyc-1];
        chk("m_to_mem_addr", to_mem_addr, m_addr);
        chk("m_wdata",       core_to_mem_data, m_wdata);
        chk("m_we",          {15'd0, core_to_mem_write_enable}, {15'd0, e_we});
        chk("m_if_rvalid",   {15'd0, if_rvalid}, {15'd0, e_ifv});
        chk("m_ma_rvalid",   {15'd0, ma_rvalid}, {15'd0, e_mav});
        chk("m_if_rdata",    if_rdata, m_ifd);
        chk("m_ma_rdata",    ma_rdata, m_mad);
      end

      if (rst || !if_req || k == K_IF) m_starve = 0;
      else if (k != K_NONE && m_starve < 3) m_starve = m_starve + 1;
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic set(input logic ir, input logic [15:0] ia, input logic mr, input logic mw,
                     input logic [15:0] ma, input logic [15:0] md, input logic [15:0] fd);
    if_req = ir; if_addr = ia; ma_req = mr; ma_we = mw;
    ma_addr = ma; ma_wdata = md; from_mem_data = fd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mid();
    chk("rst_addr",   to_mem_addr, 16'h0000);
    chk("rst_wdata",  core_to_mem_data, 16'h0000);
    chk("rst_we",     {15'd0, core_to_mem_write_enable}, 16'h0000);
    chk("rst_rvalid", {14'd0, if_rvalid, ma_rvalid}, 16'h0000);
    chk("rst_rdata",  if_rdata | ma_rdata, 16'h0000);

    // IF-only read
    next(); set(1, 16'h0010, 0, 0, 0, 0, 0);
    mid();  chk("ifonly_gnt", {15'd0, if_gnt}, 16'h0001);
    next(); set(0, 0, 0, 0, 0, 0, 16'hBEEF);
    mid();  chk("ifonly_addr", to_mem_addr, 16'h0010);
    next(); set(0, 0, 0, 0, 0, 0, 16'h0000);
    mid();  chk("ifonly_rvalid", {15'd0, if_rvalid}, 16'h0001);
            chk("ifonly_rdata", if_rdata, 16'hBEEF);
    next();
    mid();  chk("ifonly_pulse_end", {15'd0, if_rvalid}, 16'h0000);
            chk("ifonly_rdata_hold", if_rdata, 16'hBEEF);

    // Conflict: MA read wins
    next(); set(1, 16'h0020, 1, 0, 16'h0100, 0, 0);
    mid();  chk("conf_ma_gnt", {15'd0, ma_gnt}, 16'h0001);
            chk("conf_if_stall", {15'd0, if_stall}, 16'h0001);
    next(); set(0, 0, 0, 0, 0, 0, 16'h5555);
    mid();  chk("conf_addr", to_mem_addr, 16'h0100);
    next(); set(0, 0, 0, 0, 0, 0, 16'h0000);
    mid();  chk("conf_ma_rvalid", {15'd0, ma_rvalid}, 16'h0001);
            chk("conf_ma_rdata", ma_rdata, 16'h5555);
            chk("conf_no_if_rvalid", {15'd0, if_rvalid}, 16'h0000);

    // Starvation: MA MA MA IF repeating
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      next(); set(1, 16'h0030 + 16'(i), 1, 0, 16'h0300 + 16'(i), 0, 16'(i));
      mid();
      chk("starve_if_gnt", {15'd0, if_gnt}, {15'd0, pat[i]});
      chk("starve_ma_gnt", {15'd0, ma_gnt}, {15'd0, !pat[i]});
      chk("starve_stall",  {15'd0, if_stall}, {15'd0, !pat[i]});
    end

    // MA write
    next(); set(0, 0, 1, 1, 16'h0200, 16'h1234, 0);
    mid();  chk("wr_gnt", {15'd0, ma_gnt}, 16'h0001);
    next(); set(0, 0, 0, 0, 0, 0, 0);
    mid();  chk("wr_addr", to_mem_addr, 16'h0200);
            chk("wr_data", core_to_mem_data, 16'h1234);
            chk("wr_we", {15'd0, core_to_mem_write_enable}, 16'h0001);
    next();
    mid();  chk("wr_we_end", {15'd0, core_to_mem_write_enable}, 16'h0000);
            chk("wr_no_rvalid", {15'd0, ma_rvalid}, 16'h0000);

    // Interleaved IF then MA reads
    next(); set(1, 16'h0040, 0, 0, 0, 0, 0);
    mid();  chk("il_if_gnt", {15'd0, if_gnt}, 16'h0001);
    next(); set(0, 0, 1, 0, 16'h0044, 0, 16'h1111);
    mid();  chk("il_ma_gnt", {15'd0, ma_gnt}, 16'h0001);
    next(); set(0, 0, 0, 0, 0, 0, 16'h2222);
    mid();  chk("il_if_rvalid", {15'd0, if_rvalid}, 16'h0001);
            chk("il_if_rdata", if_rdata, 16'h1111);
            chk("il_ma_early", {15'd0, ma_rvalid}, 16'h0000);
    next(); set(0, 0, 0, 0, 0, 0, 16'h0000);
    mid();  chk("il_ma_rvalid", {15'd0, ma_rvalid}, 16'h0001);
            chk("il_ma_rdata", ma_rdata, 16'h2222);
            chk("il_if_end", {15'd0, if_rvalid}, 16'h0000);

    // Reset mid-read
    next(); set(1, 16'h0050, 0, 0, 0, 0, 0);
    mid();  chk("rr_gnt", {15'd0, if_gnt}, 16'h0001);
    next(); rst = 1'b1; set(1, 16'h0050, 1, 1, 16'h0060, 16'h7777, 16'hAAAA);
    mid();  chk("rr_gnt_in_rst", {14'd0, if_gnt, ma_gnt}, 16'h0000);
            chk("rr_stall_in_rst", {15'd0, if_stall}, 16'h0000);
    next(); rst = 1'b0; set(0, 0, 0, 0, 0, 0, 0);
    mid();  chk("rr_rvalid", {14'd0, if_rvalid, ma_rvalid}, 16'h0000);
            chk("rr_addr", to_mem_addr, 16'h0000);
            chk("rr_rdata", if_rdata | ma_rdata, 16'h0000);
            chk("rr_we", {15'd0, core_to_mem_write_enable}, 16'h0000);
            chk("rr_wdata", core_to_mem_data, 16'h0000);
    next();
    mid();  chk("rr_rvalid_late", {15'd0, if_rvalid}, 16'h0000);

    // Pseudo-random traffic, checked by the model only
    for (int i = 0; i < 200; i++) begin
      next();
      rst = ($urandom_range(0, 39) == 0);
      set(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
          16'($urandom), 16'($urandom), 16'($urandom));
    end
    next(); rst = 1'b0; set(0, 0, 0, 0, 0, 0, 0);
    repeat (3) next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
